// File: rtl/shape_display_ctrl.sv
// Debounces per-frame shape classifier flags and drives a one-hot label select.
// A label must persist CONFIRM_FRAMES frames to show and stays shown at least HOLD_CYCLES.
module shape_display_ctrl #(
    parameter int unsigned CONFIRM_FRAMES = 3,
    parameter int unsigned HOLD_CYCLES    = 25000000
) (
    input  logic clk,
    input  logic reset,
    input  logic frame_valid,
    input  logic circle_det,
    input  logic square_det,
    input  logic triangle_det,
    output logic circle,
    output logic square,
    output logic triangle,
    output logic label_change
);

    localparam int unsigned    TW        = $clog2(HOLD_CYCLES + 1);
    localparam logic [TW-1:0]  HOLD_INIT = TW'(HOLD_CYCLES);
    localparam logic [3:0]     CONF      = 4'(CONFIRM_FRAMES);

    typedef enum logic [1:0] {IDLE, CONFIRM, SHOW} state_t;
    typedef enum logic [1:0] {NONE, CIRC, SQR, TRI} shape_t;

    state_t         state_q, state_d;
    shape_t         cand;
    shape_t         cand_q, cand_d;
    shape_t         shown_q, shown_d;
    shape_t         chal_q, chal_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [3:0]     none_cnt_q, none_cnt_d;
    logic [3:0]     chal_cnt_q, chal_cnt_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic [2:0]     sel_q, sel_d;
    logic           chg_q, chg_d;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    // Zero or multiple flags both classify as NONE.
    always_comb begin
        cand = NONE;
        case ({circle_det, square_det, triangle_det})
            3'b100:  cand = CIRC;
            3'b010:  cand = SQR;
            3'b001:  cand = TRI;
            default: cand = NONE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cand_q     <= NONE;
            shown_q    <= NONE;
            chal_q     <= NONE;
            cnt_q      <= '0;
            none_cnt_q <= '0;
            chal_cnt_q <= '0;
            timer_q    <= '0;
            sel_q      <= '0;
            chg_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cand_q     <= cand_d;
            shown_q    <= shown_d;
            chal_q     <= chal_d;
            cnt_q      <= cnt_d;
            none_cnt_q <= none_cnt_d;
            chal_cnt_q <= chal_cnt_d;
            timer_q    <= timer_d;
            sel_q      <= sel_d;
            chg_q      <= chg_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cand_d     = cand_q;
        shown_d    = shown_q;
        chal_d     = chal_q;
        cnt_d      = cnt_q;
        none_cnt_d = none_cnt_q;
        chal_cnt_d = chal_cnt_q;
        timer_d    = timer_q;
        case (state_q)
            IDLE: begin
                if (frame_valid && cand != NONE) begin
                    cand_d = cand;
                    cnt_d  = 4'd1;
                    if (CONF == 4'd1) begin
                        state_d    = SHOW;
                        shown_d    = cand;
                        timer_d    = HOLD_INIT;
                        none_cnt_d = '0;
                        chal_cnt_d = '0;
                    end else begin
                        state_d = CONFIRM;
                    end
                end
            end
            CONFIRM: begin
                if (frame_valid) begin
                    if (cand == NONE) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cand == cand_q) begin
                        cnt_d = sat_inc(cnt_q);
                        if (sat_inc(cnt_q) == CONF) begin
                            state_d    = SHOW;
                            shown_d    = cand_q;
                            timer_d    = HOLD_INIT;
                            none_cnt_d = '0;
                            chal_cnt_d = '0;
                        end
                    end else begin
                        cand_d = cand;
                        cnt_d  = 4'd1;
                    end
                end
            end
            SHOW: begin
                timer_d = (timer_q == '0) ? '0 : timer_q - TW'(1);
                // Decisions use registered counters and pre-empt any frame in the same cycle.
                if (timer_q == '0 && chal_cnt_q >= CONF) begin
                    shown_d    = chal_q;
                    timer_d    = HOLD_INIT;
                    none_cnt_d = '0;
                    chal_cnt_d = '0;
                end else if (timer_q == '0 && none_cnt_q >= CONF) begin
                    state_d    = IDLE;
                    cnt_d      = '0;
                    none_cnt_d = '0;
                    chal_cnt_d = '0;
                end else if (frame_valid) begin
                    if (cand == shown_q) begin
                        none_cnt_d = '0;
                        chal_cnt_d = '0;
                    end else if (cand == NONE) begin
                        none_cnt_d = sat_inc(none_cnt_q);
                        chal_cnt_d = '0;
                    end else begin
                        none_cnt_d = '0;
                        if (cand == chal_q) begin
                            chal_cnt_d = sat_inc(chal_cnt_q);
                        end else begin
                            chal_d     = cand;
                            chal_cnt_d = 4'd1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are derived from next state so they register on the deciding edge.
    always_comb begin
        sel_d = '0;
        if (state_d == SHOW) begin
            case (shown_d)
                CIRC:    sel_d = 3'b100;
                SQR:     sel_d = 3'b010;
                TRI:     sel_d = 3'b001;
                default: sel_d = '0;
            endcase
        end
        chg_d = (sel_d != sel_q);
    end

    assign {circle, square, triangle} = sel_q;
    assign label_change = chg_q;

endmodule

// File: tb/tb_shape_display_ctrl.sv
// Scoreboard bench for shape_display_ctrl: stimulus queues expected label changes,
// a monitor pops them on every label_change pulse and checks held outputs each cycle.
module tb_shape_display_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic frame_valid = 1'b0;
    logic circle_det = 1'b0;
    logic square_det = 1'b0;
    logic triangle_det = 1'b0;
    logic circle, square, triangle, label_change;

    typedef struct {
        int         ecyc;
        logic [2:0] val;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    bit   done = 1'b0;

    shape_display_ctrl #(
        .CONFIRM_FRAMES(3),
        .HOLD_CYCLES(20)
    ) dut (
        .clk(clk),
        .reset(reset),
        .frame_valid(frame_valid),
        .circle_det(circle_det),
        .square_det(square_det),
        .triangle_det(triangle_det),
        .circle(circle),
        .square(square),
        .triangle(triangle),
        .label_change(label_change)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string name, input logic [2:0] act, input logic [2:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%b expected=%b", name, cyc, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Stimulus tasks are entered right after a falling edge.
    task automatic frame(input logic c, input logic s, input logic t);
        frame_valid  = 1'b1;
        circle_det   = c;
        square_det   = s;
        triangle_det = t;
        @(negedge clk);
        frame_valid  = 1'b0;
        circle_det   = 1'b0;
        square_det   = 1'b0;
        triangle_det = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic expect_chg(input int ecyc, input logic [2:0] v);
        exp_t e;
        e.ecyc = ecyc;
        e.val  = v;
        sb.push_back(e);
    endtask

    task automatic rst_pulse();
        #2 reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
    endtask

    // Monitor / checker
    initial begin
        logic [2:0] exp_out;
        logic [2:0] cur;
        exp_t       e;
        exp_out = 3'b000;
        while (!done) begin
            @(negedge clk or posedge reset);
            if (reset) begin
                #1;
                check_val("rst_out", {circle, square, triangle}, 3'b000);
                check_val("rst_chg", {2'b00, label_change}, 3'b000);
                exp_out = 3'b000;
            end else begin
                cur = {circle, square, triangle};
                if (label_change) begin
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_chg cyc=%0d got=%b expected=no change", cyc, cur);
                    end else begin
                        e = sb.pop_front();
                        check_int("chg_cycle", cyc, e.ecyc);
                        check_val("chg_value", cur, e.val);
                        exp_out = e.val;
                    end
                end
                check_val("hold_out", cur, exp_out);
            end
        end
        check_int("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running expected=finished");
        $fatal(1, "timeout");
    end

    // Stimulus
    initial begin
        int a, b, c, d, e;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Square confirmed on third frame, then cleared by empty frames after hold.
        frame(1'b0, 1'b1, 1'b0);
        frame(1'b0, 1'b1, 1'b0);
        a = cyc + 1;
        expect_chg(a, 3'b010);
        frame(1'b0, 1'b1, 1'b0);
        expect_chg(a + 21, 3'b000);
        repeat (6) frame(1'b0, 1'b0, 1'b0);

        // Circle run interrupted by triangles: triangle needs three of its own.
        frame(1'b1, 1'b0, 1'b0);
        frame(1'b1, 1'b0, 1'b0);
        frame(1'b0, 1'b0, 1'b1);
        frame(1'b0, 1'b0, 1'b1);
        b = cyc + 1;
        expect_chg(b, 3'b001);
        frame(1'b0, 1'b0, 1'b1);

        // Challenger square collected early in hold; switch happens when timer expires.
        expect_chg(b + 21, 3'b010);
        repeat (3) frame(1'b0, 1'b1, 1'b0);
        repeat (10) @(negedge clk);
        c = b + 21;

        // Ambiguous frames clear the label; decision coincides with a frame at c+21.
        expect_chg(c + 21, 3'b000);
        repeat (6) frame(1'b1, 1'b1, 1'b0);

        // Ambiguous frame in CONFIRM restarts the count.
        frame(1'b1, 1'b0, 1'b0);
        frame(1'b1, 1'b0, 1'b0);
        frame(1'b1, 1'b1, 1'b0);
        frame(1'b1, 1'b0, 1'b0);
        frame(1'b1, 1'b0, 1'b0);
        d = cyc + 1;
        expect_chg(d, 3'b100);
        frame(1'b1, 1'b0, 1'b0);

        // Reset mid-SHOW, then mid-CONFIRM; three fresh frames needed afterwards.
        repeat (2) @(negedge clk);
        rst_pulse();
        frame(1'b1, 1'b0, 1'b0);
        frame(1'b1, 1'b0, 1'b0);
        rst_pulse();
        frame(1'b1, 1'b0, 1'b0);
        frame(1'b1, 1'b0, 1'b0);
        e = cyc + 1;
        expect_chg(e, 3'b100);
        frame(1'b1, 1'b0, 1'b0);

        repeat (4) @(negedge clk);
        done = 1'b1;
    end

endmodule
